// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ requesters.
// Transfers run IDLE -> BUSY -> DONE. A transfer is aborted with req_err when the memory stalls TIMEOUT cycles.
module mem_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 16,
  parameter  int TIMEOUT    = 15,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_wr_rd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          req_err,
  output logic [WIDTH-1:0]              req_rdata,
  output logic                          mem_valid,
  output logic                          mem_wr_rd,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [WIDTH-1:0]              mem_wdata,
  input  logic [WIDTH-1:0]              mem_rdata,
  input  logic                          mem_ready
);
  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                  state_q;
  logic [GW-1:0]           gnt_q;
  logic [7:0]              cnt_q;
  logic [NUM_REQ-1:0]      req_ready_q;
  logic                    req_err_q;
  logic [WIDTH-1:0]        req_rdata_q;
  logic                    mem_valid_q;
  logic                    mem_wr_rd_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [WIDTH-1:0]        mem_wdata_q;

  logic [GW-1:0]           pick_d;
  logic                    pick_vld_d;

  // Walk the circle downward so the last hit is the nearest one after gnt_q.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_d     = gnt_q;
    for (int d = NUM_REQ; d >= 1; d--) begin
      if (req_valid[(int'(gnt_q) + d) % NUM_REQ]) begin
        pick_vld_d = 1'b1;
        pick_d     = GW'((int'(gnt_q) + d) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= GW'(NUM_REQ - 1);
      cnt_q       <= '0;
      req_ready_q <= '0;
      req_err_q   <= 1'b0;
      req_rdata_q <= '0;
      mem_valid_q <= 1'b0;
      mem_wr_rd_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            gnt_q       <= pick_d;
            mem_valid_q <= 1'b1;
            mem_wr_rd_q <= req_wr_rd[pick_d];
            mem_addr_q  <= req_addr[pick_d*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_q <= req_wdata[pick_d*WIDTH +: WIDTH];
            cnt_q       <= '0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          // A ready arriving on the last allowed cycle still completes normally.
          if (mem_ready) begin
            if (!mem_wr_rd_q) req_rdata_q <= mem_rdata;
            req_ready_q <= NUM_REQ'(1) << gnt_q;
            req_err_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            state_q     <= DONE;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            req_ready_q <= NUM_REQ'(1) << gnt_q;
            req_err_q   <= 1'b1;
            mem_valid_q <= 1'b0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          req_ready_q <= '0;
          req_err_q   <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign req_err   = req_err_q;
  assign req_rdata = req_rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_wr_rd = mem_wr_rd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: queue-driven requesters, a latency-randomised memory, and a
// reference that predicts grants, fields, latency, errors and read data from the rules.
module tb_mem_arbiter;
  localparam int N = 4, W = 8, D = 16, TO = 15, AW = 4;

  typedef struct packed {logic wr; logic [AW-1:0] addr; logic [W-1:0] wd;} op_t;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0, req_wr_rd = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*W-1:0]  req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic            req_err, mem_valid, mem_wr_rd;
  logic [W-1:0]    req_rdata, mem_wdata;
  logic [AW-1:0]   mem_addr;
  logic [W-1:0]    mem_rdata = '0;
  logic            rdy_m = 1'b0, stray = 1'b0;
  wire             mem_ready = rdy_m | stray;

  mem_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr_rd(req_wr_rd),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .req_err(req_err), .req_rdata(req_rdata), .mem_valid(mem_valid),
    .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  op_t opq[N][$];
  bit  stall = 0, wild = 0;

  // Input snapshot at each active edge: what the arbiter saw when it decided.
  bit              rst_e = 1;
  logic [N-1:0]    pend_e = '0, wr_e = '0;
  logic [N*AW-1:0] addr_e = '0;
  logic [N*W-1:0]  wd_e = '0;
  always @(posedge clk) begin
    rst_e  <= rst;
    pend_e <= req_valid;
    wr_e   <= req_wr_rd;
    addr_e <= req_addr;
    wd_e   <= req_wdata;
  end

  logic [W-1:0] dev[D];
  logic [W-1:0] rmem[D];
  logic [W-1:0] exp_rdata = '0;
  int  last = N - 1, exp_win = 0, busy_cnt = 0, resp_lat = -1, wcnt = 0, mlat = 0;
  bit  in_xfer = 0, prev_idle = 0, mbusy = 0;
  op_t cur;
  int  glog[$];
  int  elog[$];

  function automatic int rr_pick(input logic [N-1:0] p, input int l);
    for (int d = 1; d <= N; d++) if (p[(l + d) % N]) return (l + d) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    // reference checks
    if (rst_e) begin
      chk("rst_outputs", {5'd0, mem_valid, mem_wr_rd, mem_addr, mem_wdata, req_ready, req_err, req_rdata}, 32'd0);
      last = N - 1; in_xfer = 0; prev_idle = 1; exp_rdata = '0;
    end else begin
      if (mem_valid && !in_xfer) begin
        exp_win = rr_pick(pend_e, last);
        chk("grant_had_request", exp_win >= 0, 1);
        chk("issue_after_idle", prev_idle, 1);
        if (exp_win >= 0) begin
          cur.wr = wr_e[exp_win]; cur.addr = addr_e[exp_win*AW +: AW]; cur.wd = wd_e[exp_win*W +: W];
          chk("mem_fields", {mem_wr_rd, mem_addr, mem_wdata}, {cur.wr, cur.addr, cur.wd});
          last = exp_win; in_xfer = 1; busy_cnt = 1; resp_lat = -1;
          glog.push_back(exp_win);
        end
      end else if (mem_valid) begin
        busy_cnt++;
        chk("mem_hold", {mem_wr_rd, mem_addr, mem_wdata}, {cur.wr, cur.addr, cur.wd});
      end else if (req_ready == 0 && !in_xfer && prev_idle) begin
        chk("idle_stall", pend_e, 0);
      end
      if (req_ready != 0) begin
        if (!in_xfer) chk("ready_unexpected", req_ready, 0);
        else begin
          chk("ready_onehot", req_ready, 1 << exp_win);
          chk("valid_low_done", mem_valid, 0);
          chk("err_flag", req_err, resp_lat < 0);
          if (resp_lat < 0) chk("timeout_cycles", busy_cnt, TO);
          else begin
            chk("resp_latency", busy_cnt, resp_lat + 1);
            chk("ack_in_window", resp_lat < TO, 1);
            if (cur.wr) rmem[cur.addr] = cur.wd;
            else exp_rdata = rmem[cur.addr];
          end
          chk("rdata", req_rdata, exp_rdata);
          elog.push_back(req_err);
          in_xfer = 0;
        end
      end else if (in_xfer && !mem_valid) begin
        chk("lost_completion", req_ready, 1 << exp_win);
        in_xfer = 0;
      end
      prev_idle = !mem_valid && req_ready == 0;
    end
    // memory device
    if (!mem_valid) begin
      rdy_m = 0; mbusy = 0;
    end else if (rdy_m) begin
      rdy_m = 0;
    end else begin
      if (!mbusy) begin
        mbusy = 1; wcnt = 0;
        if (wild) begin
          mlat = int'($urandom_range(0, 19));
          mlat = (mlat < 15) ? mlat % 4 : mlat - 3;
        end else mlat = int'($urandom_range(0, 3));
      end
      if (!stall && wcnt == mlat) begin
        rdy_m = 1; resp_lat = wcnt;
        if (mem_wr_rd) begin
          dev[mem_addr] = mem_wdata;
          mem_rdata = W'($urandom);
        end else mem_rdata = dev[mem_addr];
      end else wcnt++;
    end
    // requesters
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) req_valid[i] = 0;
      if (!req_valid[i] && opq[i].size() > 0) begin
        op_t o;
        o = opq[i].pop_front();
        req_valid[i] = 1; req_wr_rd[i] = o.wr;
        req_addr[i*AW +: AW] = o.addr; req_wdata[i*W +: W] = o.wd;
      end
    end
  end

  task automatic push_op(input int r, input bit wr, input int a, input int wd);
    op_t o;
    o.wr = wr; o.addr = AW'(a); o.wd = W'(wd);
    opq[r].push_back(o);
  endtask

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (opq[i].size() > 0) return 1;
    return req_valid != 0 || in_xfer || mem_valid;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (busy() && n < budget) begin @(negedge clk); n++; end
    chk("drain_in_budget", n < budget, 1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic chk_log(input string tag, input int exp[$]);
    chk(tag, glog.size(), exp.size());
    for (int k = 0; k < glog.size() && k < exp.size(); k++) chk(tag, glog[k], exp[k]);
    glog.delete();
  endtask

  initial begin
    for (int a = 0; a < D; a++) begin dev[a] = '0; rmem[a] = '0; end
    repeat (3) @(negedge clk);
    rst = 0;

    // single write then read by requester 2
    push_op(2, 1, 15, 'hA5);
    push_op(2, 0, 15, 0);
    drain(200);
    chk_log("t1_grants", '{2, 2});
    chk("t1_rdata", req_rdata, 8'hA5);

    // round robin under contention from reset
    do_reset();
    glog.delete();
    for (int i = 0; i < N; i++) push_op(i, 1, i, 'h30 + i * 7);
    drain(300);
    chk_log("t2_order_all", '{0, 1, 2, 3});
    for (int i = 0; i < N; i++) chk("t2_mem", dev[i], 'h30 + i * 7);
    push_op(1, 1, 5, 'h11); push_op(3, 1, 6, 'h33);
    drain(200);
    chk_log("t2_order_13", '{1, 3});
    push_op(0, 0, 5, 0); push_op(3, 0, 6, 0);
    drain(200);
    chk_log("t2_order_03", '{0, 3});

    // full-depth sweep: writer 0 interleaved with reader 1
    for (int a = 0; a < D; a++) begin
      push_op(0, 1, a, int'($urandom_range(100, 200)));
      push_op(1, 0, a, 0);
    end
    drain(2000);
    chk("t3_count", glog.size(), 2 * D);
    for (int k = 0; k < glog.size(); k++) chk("t3_alternate", glog[k], k % 2);
    glog.delete();

    // timeout abort
    elog.delete();
    stall = 1;
    push_op(1, 0, 3, 0);
    drain(200);
    stall = 0;
    chk("t4_err_count", elog.size(), 1);
    if (elog.size() > 0) chk("t4_err", elog[0], 1);
    chk_log("t4_grant", '{1});

    // reset while requester 3 is in BUSY
    begin
      int n = 0;
      stall = 1;
      push_op(3, 1, 9, 'h99);
      while (!mem_valid && n < 50) begin @(negedge clk); n++; end
      chk("t5_reached_busy", mem_valid, 1);
      rst = 1;
      push_op(0, 1, 10, 'h0A);
      @(negedge clk);
      chk("t5_no_ready", req_ready, 0);
      rst = 0; stall = 0;
      glog.delete();
      drain(300);
      chk_log("t5_order", '{0, 3});
    end

    // stray ready in IDLE
    @(negedge clk); stray = 1;
    @(negedge clk); stray = 0;
    @(negedge clk);
    chk("t6_ready", req_ready, 0);
    chk("t6_valid", mem_valid, 0);
    push_op(2, 0, 9, 0);
    drain(200);
    chk_log("t6_after", '{2});

    // randomized traffic with boundary latencies around TIMEOUT
    wild = 1;
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < 12; k++)
        push_op(int'($urandom_range(0, N - 1)), bit'($urandom_range(0, 1)),
                int'($urandom_range(0, D - 1)), int'($urandom_range(0, 255)));
      drain(4000);
    end
    wild = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog got timeout exp completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single-port `memory` block (valid/ready handshake, `wr_rd`, `addr`, `wdata`, `rdata`) between `NUM_REQ` requesters. Each requester drives the same handshake the memory itself accepts. The arbiter picks one request at a time, forwards it to the memory, returns the completion (and read data) to the winner, and aborts the transfer with an error if the memory stalls too long. It sits between the datapath clients and the `memory` instance.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 8: data width; matches the memory `WIDTH`.
- `DEPTH`, 16: memory depth; `ADDR_WIDTH = $clog2(DEPTH)`.
- `TIMEOUT`, 15: maximum BUSY cycles waiting for `mem_ready` before abort (1..255).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  request strobe per requester; held until its `req_ready`.
- `req_wr_rd`  in  NUM_REQ  1 = write, 0 = read, per requester.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  requester i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_wdata`  in  NUM_REQ*WIDTH  requester i at `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `req_err`  out  1  high with `req_ready` when the transfer timed out.
- `req_rdata`  out  WIDTH  read data, shared by all requesters, valid only with `req_ready`.
- `mem_valid`, `mem_wr_rd`  out  1  to memory `valid`, `wr_rd`.
- `mem_addr`  out  ADDR_WIDTH  to memory `addr`.
- `mem_wdata`  out  WIDTH  to memory `wdata`.
- `mem_rdata`  in  WIDTH  from memory `rdata`.
- `mem_ready`  in  1  from memory `ready`.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE:**
  - If `req_valid != 0`, grant the first set bit, searching circularly from `last_grant+1`.
  - Register `grant` and set `last_grant = grant`.
  - Latch `wr_rd`, `addr` and `wdata` of the winner into the `mem_*` output registers.
  - Go to BUSY.
- **BUSY:**
  - `mem_valid` = 1 and the `mem_*` outputs are held stable.
  - Timeout counter increments each cycle.
  - When `mem_ready` = 1 is sampled: capture `mem_rdata` into `req_rdata` (reads only; writes leave `req_rdata` unchanged). Set `req_ready[grant]` = 1 and `req_err` = 0. Go to DONE.
  - When the counter reaches `TIMEOUT - 1` without `mem_ready`: set `req_ready[grant]` = 1 and `req_err` = 1. Go to DONE.
  - `mem_ready` wins if both occur in the same cycle.
- **DONE:**
  - `mem_valid` = 0.
  - `req_ready[grant]` (and `req_err` if set) is high for exactly this cycle.
  - Always go to IDLE. This bubble lets the requester drop or change `req_valid` before re-arbitration.
- **Fairness:**
  - A requester that was just served has lowest priority in the next arbitration.
  - A request raised while another transfer is in BUSY/DONE is considered at the next IDLE.
- **Requester rules:**
  - Hold `req_valid` and its fields until `req_ready`.
  - Deasserting early is illegal; the arbiter completes the latched transfer regardless.
- `mem_ready` sampled outside BUSY is ignored.
- **Reset (any state, including mid-BUSY):**
  - Next state IDLE.
  - `last_grant = NUM_REQ-1`, so requester 0 has first priority.
  - Counter cleared.
  - All outputs 0: `mem_valid`, `mem_wr_rd`, `mem_addr`, `mem_wdata`, `req_ready`, `req_err`, `req_rdata`.
  - An interrupted transfer is dropped with no `req_ready`.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Edge k: IDLE samples `req_valid`.
- Cycle k+1: `mem_valid` = 1.
- If the memory asserts `ready` in cycle k+1+L (L ≥ 0), `req_ready` is high in cycle k+2+L and IDLE is re-entered at k+3+L.
- Best-case throughput: one transfer per 3 cycles.
- Timeout abort: `req_ready` + `req_err` appear in cycle k+1+TIMEOUT.

## Test plan
- **Single write then read:** requester 2 writes addr 15, data 0xA5; after its `req_ready`, it reads addr 15 → `mem_addr` = 15, `mem_wr_rd` = 1 then 0, `req_ready[2]` pulses once per transfer, and `req_rdata` = 0xA5 with `req_err` = 0.
- **Round robin under contention:** from reset, all four requesters hold writes to addrs 0..3 → grants in order 0, 1, 2, 3. Memory contents at addrs 0..3 match the wdata. Then requesters 1 and 3 re-request → order 1, 3. Then requesters 0 and 3 re-request → order 0, 3 (last grant was 3).
- **Full-depth sweep:** requester 0 writes addrs 0..15 (random wdata 100..200) while requester 1 reads addrs 0..15 → transfers alternate 0, 1 and every read returns the data most recently written to that address.
- **Timeout:** force `mem_ready` = 0 and request from requester 1 → exactly TIMEOUT (15) BUSY cycles, then `req_ready[1]` = 1 with `req_err` = 1, `mem_valid` = 0, back to IDLE.
- **Reset mid-transfer:** assert `rst` during BUSY of requester 3 → next cycle all outputs 0 and no `req_ready`. After release with requesters 0 and 3 pending, requester 0 is granted first.
- **Ignore stray ready:** pulse `mem_ready` in IDLE with no requests → no state change, `req_ready` stays 0.
